// File: rtl/play_engine_if.sv
// Playback engine bus: control handshake, SRAM read port and DAC sample port.
// The engine uses the slave modport. The environment (control FSM, SRAM, DAC)
// uses the master modport.
interface play_engine_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 23
);
    logic              i_play_start;
    logic [ADDR_W-1:0] i_play_select;
    logic [LEN_W-1:0]  i_play_len;
    logic              i_play_stop;
    logic              o_play_done;
    logic              o_sram_req;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] i_sram_rdata;
    logic              i_sram_rvalid;
    logic              i_dac_req;
    logic [DATA_W-1:0] o_dac_data;
    logic              o_busy;

    modport slave (
        input  i_play_start, i_play_select, i_play_len, i_play_stop,
        input  i_sram_rdata, i_sram_rvalid, i_dac_req,
        output o_play_done, o_sram_req, o_sram_addr, o_dac_data, o_busy
    );

    modport master (
        output i_play_start, i_play_select, i_play_len, i_play_stop,
        output i_sram_rdata, i_sram_rvalid, i_dac_req,
        input  o_play_done, o_sram_req, o_sram_addr, o_dac_data, o_busy
    );
endinterface

// File: rtl/play_engine.sv
// Playback engine: streams DATA_W-bit samples from SRAM to the DAC serializer,
// one SRAM read per DAC request. The engine pulses done for one cycle when it
// finishes, then waits for the control FSM to drop start.
// Optional build macro PLAY_LOOP_EN: when defined, the engine restarts at base
// after the last sample and stops only on a stop request.
module play_engine #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 23
) (
    input  logic i_clk,
    input  logic i_rst_n,
    play_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, READY, DONE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] sample;
    logic              stop_seen;    // stop arrived while a read was outstanding
    logic              have_sample;  // sample register holds valid stream data
    logic              last_smp;
    logic              stop_now;

    assign last_smp = (count + LEN_W'(1)) == len;
    assign stop_now = stop_seen | bus.i_play_stop;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.i_play_start)
                       state_nxt = (bus.i_play_len == '0) ? DONE : FETCH;
            // The read in flight always completes before leaving FETCH.
            FETCH: if (bus.i_sram_rvalid)
                       state_nxt = stop_now ? DONE : READY;
            READY: begin
                if (bus.i_play_stop) state_nxt = DONE;
                else if (bus.i_dac_req) begin
`ifdef PLAY_LOOP_EN
                    state_nxt = FETCH;
`else
                    state_nxt = last_smp ? DONE : FETCH;
`endif
                end
            end
            DONE:  state_nxt = HOLD;
            HOLD:  if (!bus.i_play_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latched request, sample position, sample register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            base        <= '0;
            len         <= '0;
            count       <= '0;
            sample      <= '0;
            stop_seen   <= 1'b0;
            have_sample <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stop_seen   <= 1'b0;
                    have_sample <= 1'b0;
                    if (bus.i_play_start) begin
                        base  <= bus.i_play_select;
                        len   <= bus.i_play_len;
                        count <= '0;
                    end
                end
                FETCH: begin
                    if (bus.i_play_stop) stop_seen <= 1'b1;
                    // Data of a read cancelled by stop is dropped.
                    if (bus.i_sram_rvalid && !stop_now) begin
                        sample      <= bus.i_sram_rdata;
                        have_sample <= 1'b1;
                    end
                end
                READY: begin
                    // A sample consumed alongside stop still counts.
                    if (bus.i_dac_req) begin
`ifdef PLAY_LOOP_EN
                        count <= last_smp ? '0 : count + LEN_W'(1);
`else
                        count <= count + LEN_W'(1);
`endif
                    end
                end
                DONE: have_sample <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs are pure functions of state, so all drop to 0 at reset.
    // The previous sample stays on the DAC while the next one is fetched.
    assign bus.o_sram_req  = (state == FETCH);
    assign bus.o_sram_addr = (state == FETCH) ? base + ADDR_W'(count) : '0;
    assign bus.o_dac_data  = (have_sample && (state == FETCH || state == READY))
                             ? sample : '0;
    assign bus.o_play_done = (state == DONE);
    assign bus.o_busy      = (state != IDLE);
endmodule

// File: doc/play_engine.md
Name: play_engine

Overview:
- Playback stage directly downstream of the control FSM.
- Consumes the level-held play start, the chunk base address and the stop request.
- Streams 16-bit samples from SRAM to the audio DAC serializer, one sample per DAC request.
- Returns a single-cycle done pulse so the control FSM can return to idle.

Parameters:
ADDR_W, 23, SRAM word address width; matches the chunk select width.
DATA_W, 16, sample width.
LEN_W, 23, width of the play-length count.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_play_start  in  1  level; held high by control FSM while in PLAY
i_play_select  in  ADDR_W  chunk base word address; sampled at start
i_play_len  in  LEN_W  number of samples in chunk; sampled at start
i_play_stop  in  1  level stop request
o_play_done  out  1  one-cycle pulse at end of playback
o_sram_req  out  1  read request, held until i_sram_rvalid
o_sram_addr  out  ADDR_W  read word address
i_sram_rdata  in  DATA_W  read data, valid with i_sram_rvalid
i_sram_rvalid  in  1  one-cycle read-data strobe
i_dac_req  in  1  one-cycle pulse: DAC consumes sample now
o_dac_data  out  DATA_W  sample presented to DAC
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, i_rst_n low): state IDLE; all outputs 0; internal base, count and address registers 0. Reset mid-transfer abandons any outstanding read; an rvalid arriving after reset release is ignored in IDLE.
- States: IDLE, FETCH, READY, DONE, HOLD.
- IDLE:
  - If i_play_start=1, latch base=i_play_select, len=i_play_len, count=0.
  - If len=0, go to DONE; otherwise go to FETCH.
- FETCH:
  - o_sram_req=1, o_sram_addr=base+count, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - On i_sram_rvalid, capture i_sram_rdata into the sample register and go to READY.
  - Stop seen in FETCH is remembered. The read completes, its data is discarded, then go to DONE.
- READY:
  - o_dac_data holds the sample register.
  - On i_dac_req: count++. If count+1==len, go to DONE; otherwise go to FETCH the next cycle.
  - i_play_stop=1 in READY goes to DONE next cycle, even if i_dac_req is simultaneous. That final sample is still consumed (count increments).
- DONE:
  - o_play_done=1 for exactly one cycle.
  - o_dac_data forced to 0 from this cycle on.
  - Then go to HOLD.
- HOLD: wait until i_play_start=0, then go to IDLE. This prevents a restart while the control FSM still holds start high.
- Output rules:
  - o_dac_data is 0 in IDLE, FETCH-before-first-sample, DONE and HOLD.
  - Between samples during FETCH it holds the previous sample; no glitch to 0 mid-stream.
- i_dac_req outside READY is ignored (underrun); the DAC repeats the held value.
- Latency:
  - start to first o_sram_req: 1 cycle.
  - rvalid to sample on o_dac_data: 1 cycle.
  - last dac_req to o_play_done: 1 cycle.
- i_play_select and i_play_len changes after start are ignored.

Optional Feature:
PLAY_LOOP_EN:
- Defined: on the last sample consumed in READY, count resets to 0 and the block goes to FETCH at base (continuous loop). Only i_play_stop (or reset) reaches DONE. len=0 still goes straight to DONE.
- Undefined: playback ends at len as described above.

Test Plan:
- base=0x000100, len=3, rvalid 2 cycles after each req, dac_req every 8 cycles -> reads 0x100,0x101,0x102; o_dac_data shows the three words in order; one o_play_done pulse 1 cycle after third dac_req; HOLD until start drops.
- len=0 with start -> o_play_done one cycle later; no o_sram_req ever asserted.
- Stop asserted while FETCH req pending at count=1 -> req held until rvalid, data not presented, o_play_done next cycle, o_dac_data=0.
- Stop and dac_req same cycle in READY -> done pulse next cycle, no further SRAM read.
- i_rst_n low while FETCH with req high -> o_sram_req, o_busy, o_dac_data immediately 0; a late rvalid after release is ignored and the block stays in IDLE.
- With PLAY_LOOP_EN, base=0x7FFFFE, len=3 -> addresses 0x7FFFFE,0x7FFFFF,0x000000, then 0x7FFFFE again; no done until stop.
